// File: rtl/buffer_feed_scheduler_pkg.sv
// Shared configuration for the row-buffer feed path: FSM encoding and the
// default geometry used when the scheduler sits next to the row buffers.
package Config;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feed_state_t;

  localparam int FEED_ROWS  = 4;
  localparam int FEED_LEN_W = 8;

endpackage

// File: rtl/buffer_feed_scheduler.sv
// Read-side sequencer for the per-row operand buffers. Issues a skewed
// (diagonal) read window so row i is read from step i for len steps, and
// freezes the whole schedule whenever an active row is empty so the skew
// between rows is never broken.
module buffer_feed_scheduler
  import Config::*;
#(
  parameter int ROWS    = FEED_ROWS,
  parameter int LEN_W   = FEED_LEN_W,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rstn,      // synchronous, active-high
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic [ROWS-1:0]    empty,
  output logic [ROWS-1:0]    rd_en,
  output logic [ROWS-1:0]    valid,
  output logic               busy,
  output logic               done,
  output logic [STALL_W-1:0] stall_cnt
);

  // Step counter spans len+ROWS-2 at max len without wrapping.
  localparam int T_W = LEN_W + $clog2(ROWS) + 1;

  feed_state_t        state_q, state_d;
  logic [T_W-1:0]     t_q, t_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [T_W-1:0]     t_end;
  logic [ROWS-1:0]    active;
  logic               run;
  logic               stall;

  assign run   = (state_q == RUN);
  assign t_end = T_W'(len_q) + T_W'(ROWS - 2);

  // Per-row diagonal window: row i is live for i <= t < i+len_q.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign active[gi] = (t_q >= T_W'(gi)) && (t_q < (T_W'(gi) + T_W'(len_q)));
  end

  // Any live row without data freezes every row; idle rows' flags are don't-care.
  assign stall     = run & |(active & empty);
  assign rd_en     = {ROWS{run & ~stall}} & active;
  assign valid     = rd_en;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign stall_cnt = stall_q;

  // Next-state: schedule sequencing, step advance and saturating stall count.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    len_d   = len_q;
    stall_d = stall_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          stall_d = '0;
          if (len != '0) begin
            len_d   = len;
            t_d     = '0;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (stall) begin
          if (stall_q != '1) stall_d = stall_q + STALL_W'(1);
        end else if (t_q == t_end) begin
          state_d = DONE;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any schedule without a done pulse.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      t_q     <= '0;
      len_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      len_q   <= len_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: doc/buffer_feed_scheduler.md
# buffer_feed_scheduler

Read-side sequencer for the bank of per-row `buffer` FIFOs that feed the systolic array. On a `start` pulse it issues `rd_en` to each row buffer over a diagonal (skewed) window: row *i* is read from schedule step *i* for `len` steps. This produces the staggered operand wavefront the array expects. If any row due for a read is empty, the scheduler freezes the whole schedule so the skew stays intact. It reports busy/done and a saturating stall count.

## Interface
- `ROWS`, 4: number of row buffers/array rows.
- `LEN_W`, 8: width of the per-row transfer length.
- `STALL_W`, 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  reset; synchronous, active-high (asserted = 1) despite the name.
- `start`  in  1  begin a schedule; sampled only in IDLE.
- `len`  in  LEN_W  words per row; latched on accepted `start`.
- `empty`  in  ROWS  `empty` flags of the row buffers.
- `rd_en`  out  ROWS  read strobes to the row buffers.
- `valid`  out  ROWS  row data on the buffer `dout` is consumed this cycle (equals `rd_en`).
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse at schedule end.
- `stall_cnt`  out  STALL_W  stall cycles in the current/last schedule, saturating.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE: when `start`=1 and `len`≠0, latch `len` into `len_q`, clear `t` and `stall_cnt`, then go to RUN.
  - IDLE: when `start`=1 and `len`=0, clear `stall_cnt` and go to DONE without entering RUN.
  - RUN: step counter `t` runs from 0 to `len_q+ROWS-2`. Width of `t` is LEN_W+$clog2(ROWS)+1 bits, so there is no overflow at max `len`.
  - Row *i* is active when i ≤ t < i+`len_q`. The compare is unsigned at the full `t` width.
  - `stall` = OR over rows of (active_i & empty_i). Empty flags of inactive rows are ignored.
  - `rd_en[i]` = RUN & active_i & !stall. This is combinational from state, `t` and `empty`.
  - RUN, `!stall`: `t` increments. At `t == len_q+ROWS-2` with `!stall`, go to DONE.
  - RUN, `stall`: `t` holds, all `rd_en` are 0, and `stall_cnt` increments, saturating at all-ones.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `start` in RUN or DONE is ignored; no queuing.
- `valid` = `rd_en`. Buffer `dout` is combinational from its read pointer, so data and `valid` align in the same cycle.
- `stall_cnt` holds its value in IDLE until the next accepted `start`.

## Timing
- Reset: all outputs are 0 on the cycle after `rstn` is sampled high, including `stall_cnt` and state IDLE. Reset mid-RUN aborts the schedule with no `done` pulse. The row buffers are reset by the same `rstn`.
- `start` is accepted at edge E0. The first `rd_en[0]` is high in cycle E0+1, where `t`=0.
- Without stalls, RUN lasts `len+ROWS-1` cycles. `done` is high in the following cycle, and `busy` drops the cycle after that.
- `len`=0: `done` pulses in cycle E0+1, with no `rd_en`.
- Each stall cycle adds exactly one cycle to RUN. The `rd_en` pattern is shifted in time but otherwise identical.
- A stall is evaluated every cycle from the current `empty`. It may clear in the cycle right after it asserts.
- The earliest new `start` is accepted in the cycle after DONE, back in IDLE.

## Structure
- Shared package `Config` holds:
  - the FSM enum typedef `feed_state_t` (IDLE, RUN, DONE);
  - default constants `FEED_ROWS` and `FEED_LEN_W`, used when instantiating alongside the row buffers.
- Single module. The per-row window compare is a generate loop, with no sub-module.
- Integration: `rd_en[i]` connects to `buffer.rd_en`, and `empty[i]` comes from `buffer.empty`, all on the shared `clk`.

## Test plan
- **Basic skew.** ROWS=4, `len`=3, buffers never empty.
  - `rd_en` by cycle after start: 0001, 0011, 0111, 1110, 1100, 1000.
  - `done` in the 7th cycle; `stall_cnt`=0.
- **Stall.** Same setup, with `empty[2]`=1 for 2 cycles starting at `t`=2.
  - `rd_en`=0000 for those 2 cycles, then the pattern resumes at 0111.
  - `done` is 2 cycles later than in the basic case; `stall_cnt`=2.
- **Inactive-row empty.** `empty[3]`=1 during `t`=0..2 (row 3 not yet active).
  - No stall; timing identical to the basic case.
- **Zero length and ignored start.**
  - `len`=0 gives `done` in the next cycle with no `rd_en`.
  - A `start` pulse mid-RUN leaves `t`, `len_q` and `done` timing unchanged.
- **Reset mid-run.** Assert `rstn` at `t`=2.
  - Next cycle: `rd_en`=0, `busy`=0, `stall_cnt`=0, and no `done`.
  - A new `start` then runs normally.
- **Limits.** `len`=255 with ROWS=4.
  - 258 RUN cycles; each row is read exactly 255 times.
  - Forcing >65535 stall cycles leaves `stall_cnt`=16'hFFFF.
